mb_pattern_sequencer: RTL and testbench
=======================================

MB_PATTERN_SEQUENCER -- requirements
Module: mb_pattern_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the burst-length and iteration counters.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4, giving the idle cycles between iterations (legal range 1..255).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port i_clk, input, 1 bit: block clock; all logic on the rising edge.
REQ-005 Port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port i_start, input, 1 bit: single-cycle request to run a pattern.
REQ-007 Port i_pattern_sel, input, 4 bits: one-hot pattern select (1000 LFSR, 0100 per-lane ID, 0010 valid, 0001 clock).
REQ-008 Port i_burst_len, input, CNT_W bits: words per iteration.
REQ-009 Port i_iterations, input, CNT_W bits: number of bursts to send.
REQ-010 Port i_abort, input, 1 bit: terminate the current run.
REQ-011 Port o_seq_type, output, 4 bits: active pattern type, using the i_pattern_sel encoding; 0000 means no pattern.
REQ-012 Port o_serliazer_data_en, output, 1 bit: data-lane serializer enable.
REQ-013 Port o_serliazer_valid_en, output, 1 bit: valid-lane serializer enable.
REQ-014 Port o_clk_pattern_en, output, 1 bit: clock-lane pattern enable.
REQ-015 Port o_lfsr_seed_load, output, 1 bit: single-cycle LFSR reseed pulse.
REQ-016 Ports o_busy, o_done, o_aborted and o_req_err, outputs, 1 bit each: status; o_done, o_aborted and o_req_err are single-cycle pulses.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, SETUP, SEND, GAP and DONE.
REQ-018 In IDLE, i_start with a one-hot i_pattern_sel, nonzero i_burst_len and nonzero i_iterations SHALL latch all three inputs and move to SETUP on the next cycle.
REQ-019 In IDLE, i_start with a non-one-hot select or a zero length/count SHALL pulse o_req_err on the next cycle and leave the FSM in IDLE.
REQ-020 i_start outside IDLE SHALL be ignored, with no error pulse.
REQ-021 SETUP SHALL last 1 cycle; o_lfsr_seed_load SHALL be 1 in SETUP only, and only when the latched type is LFSR.
REQ-022 SEND SHALL last exactly burst_len cycles, counted by a word counter that resets on SEND entry.
REQ-023 At the end of a burst, the FSM SHALL go to GAP if iterations remain, otherwise to DONE.
REQ-024 GAP SHALL last GAP_CYCLES cycles and then return to SEND; the iteration counter SHALL decrement on each SEND exit.
REQ-025 DONE SHALL last 1 cycle, assert o_done, then return to IDLE.
REQ-026 In SEND only, for the LFSR and per-lane ID types: data_en=1 and valid_en=1.
REQ-027 In SEND only, for the valid type: valid_en=1 and data_en=0.
REQ-028 In SEND only, for the clock type: o_clk_pattern_en=1, data_en=0 and valid_en=0.
REQ-029 All enables SHALL be 0 in every state other than SEND.
REQ-030 o_seq_type SHALL equal the latched type in SETUP, SEND and GAP, and 0000 in IDLE and DONE.
REQ-031 o_busy SHALL be 1 in every state other than IDLE.
REQ-032 All outputs SHALL be registered, with 1-cycle latency from the state change.
REQ-033 i_abort in any state other than IDLE SHALL send the FSM to IDLE on the next cycle, drop all enables, pulse o_aborted and suppress o_done.
REQ-034 i_abort in IDLE SHALL be ignored.
REQ-035 If i_abort and the last SEND word occur in the same cycle, abort SHALL win.
REQ-036 Counters SHALL NOT wrap: a burst_len or iteration count equal to 2^CNT_W-1 SHALL run to completion.
REQ-037 The inputs i_burst_len and i_iterations SHALL be sampled only at start; later changes SHALL have no effect on the current run.

Reset
REQ-038 While i_rst is 1, the FSM SHALL be in IDLE and all counters and latches SHALL be 0.
REQ-039 While i_rst is 1, all outputs SHALL be 0, including o_seq_type=0000.
REQ-040 Reset mid-run SHALL override abort and emit no o_aborted or o_done pulse.

Structure
REQ-041 The seq_type one-hot encodings and the FSM state enum SHALL reside in the shared package mb_pkg.
REQ-042 The block SHALL have no sub-module; counters and the FSM SHALL be implemented inline.

Verification
REQ-043 LFSR, burst_len=3, iterations=2: seed_load 1 cycle, then 3 cycles of data_en=valid_en=1, 4 gap cycles, 3 more enable cycles, o_done, then IDLE.
REQ-044 Valid pattern, burst_len=5, iterations=1: valid_en=1 for 5 cycles, data_en=0 throughout, o_seq_type=0010 during the run.
REQ-045 i_pattern_sel=0110, or i_burst_len=0: o_req_err pulses once, o_busy stays 0.
REQ-046 i_abort on the 2nd SEND cycle of an 8-word burst: all enables 0 next cycle, o_aborted=1, no o_done.
REQ-047 i_rst asserted during GAP: all outputs 0 next cycle; a subsequent start runs normally.
REQ-048 i_start during SEND with different inputs: ignored, and the current run completes unchanged.

Source files
------------

// File: rtl/mb_pkg.sv
// Shared types for the pattern sequencer: pattern-type one-hot codes, FSM states
// and the request-select validity helper.
package mb_pkg;

  typedef enum logic [3:0] {
    SEQ_NONE  = 4'b0000,
    SEQ_CLK   = 4'b0001,
    SEQ_VALID = 4'b0010,
    SEQ_ID    = 4'b0100,
    SEQ_LFSR  = 4'b1000
  } seq_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_e;

  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/mb_pattern_sequencer.sv
// Burst pattern sequencer: runs SETUP / SEND / GAP iterations for one selected
// lane pattern and drives registered serializer enables and status pulses.
module mb_pattern_sequencer
  import mb_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_pattern_sel,
  input  logic [CNT_W-1:0] i_burst_len,
  input  logic [CNT_W-1:0] i_iterations,
  input  logic             i_abort,
  output logic [3:0]       o_seq_type,
  output logic             o_serliazer_data_en,
  output logic             o_serliazer_valid_en,
  output logic             o_clk_pattern_en,
  output logic             o_lfsr_seed_load,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic             o_req_err
);

  localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  seq_type_e        type_q, type_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [7:0]       gap_q, gap_d;

  logic [3:0] seq_type_q, seq_type_d;
  logic       data_en_q, data_en_d;
  logic       valid_en_q, valid_en_d;
  logic       clk_en_q, clk_en_d;
  logic       seed_q, seed_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;
  logic       req_err_q, req_err_d;

  logic start_ok;
  logic abort_hit;

  assign start_ok  = i_start && is_one_hot4(i_pattern_sel) &&
                     (i_burst_len != '0) && (i_iterations != '0);
  assign abort_hit = i_abort && (state_q != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      type_q     <= SEQ_NONE;
      len_q      <= '0;
      iter_q     <= '0;
      word_q     <= '0;
      gap_q      <= '0;
      seq_type_q <= 4'b0000;
      data_en_q  <= 1'b0;
      valid_en_q <= 1'b0;
      clk_en_q   <= 1'b0;
      seed_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      req_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      len_q      <= len_d;
      iter_q     <= iter_d;
      word_q     <= word_d;
      gap_q      <= gap_d;
      seq_type_q <= seq_type_d;
      data_en_q  <= data_en_d;
      valid_en_q <= valid_en_d;
      clk_en_q   <= clk_en_d;
      seed_q     <= seed_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      req_err_q  <= req_err_d;
    end
  end

  // Word counter runs 1..len and iteration counter counts down to 1, so an
  // all-ones length or count completes without wrapping.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    len_d   = len_q;
    iter_d  = iter_q;
    word_d  = word_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          type_d  = seq_type_e'(i_pattern_sel);
          len_d   = i_burst_len;
          iter_d  = i_iterations;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        word_d  = CNT_ONE;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (word_q == len_q) begin
          iter_d = iter_q - CNT_ONE;
          if (iter_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else begin
            gap_d   = 8'd1;
            state_d = ST_GAP;
          end
        end else begin
          word_d = word_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          word_d  = CNT_ONE;
          state_d = ST_SEND;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_d = ST_IDLE;
    end
  end

  // Outputs are decoded from the upcoming state so the registered values line
  // up with the state they describe.
  always_comb begin
    seq_type_d = 4'b0000;
    data_en_d  = 1'b0;
    valid_en_d = 1'b0;
    clk_en_d   = 1'b0;
    seed_d     = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    aborted_d  = abort_hit;
    req_err_d  = (state_q == ST_IDLE) && i_start && !start_ok;
    if (state_d == ST_SETUP || state_d == ST_SEND || state_d == ST_GAP) begin
      seq_type_d = type_d;
    end
    if (state_d == ST_SETUP) begin
      seed_d = (type_d == SEQ_LFSR);
    end
    if (state_d == ST_SEND) begin
      data_en_d  = (type_d == SEQ_LFSR) || (type_d == SEQ_ID);
      valid_en_d = (type_d == SEQ_LFSR) || (type_d == SEQ_ID) || (type_d == SEQ_VALID);
      clk_en_d   = (type_d == SEQ_CLK);
    end
  end

  assign o_seq_type           = seq_type_q;
  assign o_serliazer_data_en  = data_en_q;
  assign o_serliazer_valid_en = valid_en_q;
  assign o_clk_pattern_en     = clk_en_q;
  assign o_lfsr_seed_load     = seed_q;
  assign o_busy               = busy_q;
  assign o_done               = done_q;
  assign o_aborted            = aborted_q;
  assign o_req_err            = req_err_q;

endmodule

// File: tb/tb_mb_pattern_sequencer.sv
// Self-checking bench for mb_pattern_sequencer: directed vector table, corner
// sequences and randomized traffic against a trace-expanding reference model.
module tb_mb_pattern_sequencer;

  localparam int CW  = 4;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [3:0]    sel;
  logic [CW-1:0] bl, it;
  logic [3:0]    seq;
  logic          den, ven, cen, seed, busy, done, abt, err;

  always #5 clk = ~clk;

  mb_pattern_sequencer #(.CNT_W(CW), .GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pattern_sel(sel),
    .i_burst_len(bl), .i_iterations(it), .i_abort(abort),
    .o_seq_type(seq), .o_serliazer_data_en(den), .o_serliazer_valid_en(ven),
    .o_clk_pattern_en(cen), .o_lfsr_seed_load(seed), .o_busy(busy),
    .o_done(done), .o_aborted(abt), .o_req_err(err)
  );

  // Output vector layout: {seq_type[3:0], data_en, valid_en, clk_en, seed, busy, done, aborted, req_err}
  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  logic        prev_busy = 1'b0;
  logic [11:0] got;

  typedef struct {
    logic          r, s, a;
    logic [3:0]    ps;
    logic [CW-1:0] l, n;
    logic [11:0]   e;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [11:0] g, input logic [11:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, g, e, $time);
    end
  endtask

  // Expand one accepted request into its full per-cycle output trace.
  task automatic build(input logic [3:0] t, input int L, input int N);
    logic d, v, c;
    d = (t == 4'b1000) || (t == 4'b0100);
    v = d || (t == 4'b0010);
    c = (t == 4'b0001);
    exp_q.push_back({t, 3'b000, (t == 4'b1000), 1'b1, 3'b000});
    for (int n = 0; n < N; n++) begin
      for (int w = 0; w < L; w++) exp_q.push_back({t, d, v, c, 1'b0, 1'b1, 3'b000});
      if (n < N - 1)
        for (int g = 0; g < GAP; g++) exp_q.push_back({t, 4'b0000, 1'b1, 3'b000});
    end
    exp_q.push_back(12'b0000_0000_1100);
  endtask

  task automatic step(input logic r, input logic s, input logic a, input logic [3:0] ps,
                      input logic [CW-1:0] l, input logic [CW-1:0] n, input string tag);
    logic [11:0] e;
    rst = r; start = s; abort = a; sel = ps; bl = l; it = n;
    if (r) begin
      exp_q.delete();
      e = '0;
    end else if (prev_busy) begin
      if (a) begin
        exp_q.delete();
        e = 12'b0000_0000_0010;
      end else if (exp_q.size() == 0) begin
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
    end else if (s) begin
      if ($countones(ps) == 1 && l != 0 && n != 0) begin
        build(ps, int'(l), int'(n));
        e = exp_q.pop_front();
      end else begin
        e = 12'b0000_0000_0001;
      end
    end else begin
      e = '0;
    end
    prev_busy = e[3];
    @(posedge clk);
    @(negedge clk);
    got = {seq, den, ven, cen, seed, busy, done, abt, err};
    check(tag, got, e);
  endtask

  task automatic add(input logic r, input logic s, input logic a, input logic [3:0] ps,
                     input logic [CW-1:0] l, input logic [CW-1:0] n, input logic [11:0] e);
    vec_t v;
    v.r = r; v.s = s; v.a = a; v.ps = ps; v.l = l; v.n = n; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input int k, input logic [11:0] e);
    for (int i = 0; i < k; i++) add(1'b0, 1'b0, 1'b0, 4'b0000, '0, '0, e);
  endtask

  initial begin
    int dcount, steps;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sel = '0; bl = '0; it = '0;

    add(1, 0, 0, 4'b0000, 0, 0, 12'b0000_0000_0000);
    // LFSR 3 words x 2 iterations
    add(0, 1, 0, 4'b1000, 3, 2, 12'b1000_0001_1000);
    add_idle(3, 12'b1000_1100_1000);
    add_idle(4, 12'b1000_0000_1000);
    add_idle(3, 12'b1000_1100_1000);
    add_idle(1, 12'b0000_0000_1100);
    add_idle(1, 12'b0000_0000_0000);
    // malformed requests
    add(0, 1, 0, 4'b0110, 3, 2, 12'b0000_0000_0001);
    add_idle(1, 12'b0000_0000_0000);
    add(0, 1, 0, 4'b1000, 0, 2, 12'b0000_0000_0001);
    add_idle(1, 12'b0000_0000_0000);
    add(0, 1, 0, 4'b0001, 2, 0, 12'b0000_0000_0001);
    add(0, 0, 1, 4'b0000, 0, 0, 12'b0000_0000_0000);
    // valid pattern 5 words x 1
    add(0, 1, 0, 4'b0010, 5, 1, 12'b0010_0000_1000);
    add_idle(5, 12'b0010_0100_1000);
    add_idle(1, 12'b0000_0000_1100);
    add_idle(1, 12'b0000_0000_0000);
    // clock pattern; second start during SEND is ignored
    add(0, 1, 0, 4'b0001, 2, 1, 12'b0001_0000_1000);
    add_idle(1, 12'b0001_0010_1000);
    add(0, 1, 0, 4'b1000, 7, 3, 12'b0001_0010_1000);
    add_idle(1, 12'b0000_0000_1100);
    add_idle(1, 12'b0000_0000_0000);
    // abort on the 2nd SEND cycle of an 8-word burst
    add(0, 1, 0, 4'b0100, 8, 1, 12'b0100_0000_1000);
    add_idle(2, 12'b0100_1100_1000);
    add(0, 0, 1, 4'b0000, 0, 0, 12'b0000_0000_0010);
    add_idle(2, 12'b0000_0000_0000);
    // abort coincident with the last word wins over done
    add(0, 1, 0, 4'b0100, 2, 1, 12'b0100_0000_1000);
    add_idle(2, 12'b0100_1100_1000);
    add(0, 0, 1, 4'b0000, 0, 0, 12'b0000_0000_0010);
    add_idle(2, 12'b0000_0000_0000);
    // reset during GAP, then a normal run
    add(0, 1, 0, 4'b0010, 1, 2, 12'b0010_0000_1000);
    add_idle(1, 12'b0010_0100_1000);
    add_idle(1, 12'b0010_0000_1000);
    add(1, 0, 0, 4'b0000, 0, 0, 12'b0000_0000_0000);
    add(0, 1, 0, 4'b1000, 1, 1, 12'b1000_0001_1000);
    add_idle(1, 12'b1000_1100_1000);
    add_idle(1, 12'b0000_0000_1100);
    add_idle(1, 12'b0000_0000_0000);
    // reset together with abort: no aborted pulse
    add(0, 1, 0, 4'b0001, 3, 1, 12'b0001_0000_1000);
    add(1, 0, 1, 4'b0000, 0, 0, 12'b0000_0000_0000);
    add_idle(2, 12'b0000_0000_0000);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].ps, tbl[i].l, tbl[i].n, "model");
      check($sformatf("vec%0d", i), got, tbl[i].e);
    end

    // All-ones length and count must complete without wrapping.
    step(0, 1, 0, 4'b1000, 4'hF, 4'hF, "max_start");
    dcount = 0;
    steps  = 0;
    for (int i = 0; i < 400; i++) begin
      step(0, 0, 0, 4'b0000, '0, '0, "max_run");
      steps++;
      if (den) dcount++;
      if (done) break;
    end
    check("max_data_words", 12'(dcount), 12'd225);
    check("max_cycles_to_done", 12'(steps), 12'(225 + 14 * GAP + 1));
    step(0, 0, 0, 4'b0000, '0, '0, "max_idle");

    for (int i = 0; i < 3000; i++) begin
      logic          r, s, a;
      logic [3:0]    ps;
      logic [CW-1:0] l, n;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 5) == 0);
      a  = ($urandom_range(0, 39) == 0);
      ps = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
      l  = CW'($urandom_range(0, 4));
      n  = CW'($urandom_range(0, 3));
      step(r, s, a, ps, l, n, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
